// File: rtl/em_pkg.sv
// em_pkg: shared constants and LFSR step for the stochastic edge memory
package em_pkg;
    localparam int EM_DEPTH = 32;
    localparam int EM_AW = 5;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED0 = 16'hACE1;
    localparam logic [15:0] DEF_SEED1 = 16'h1D2B;
    localparam logic [15:0] DEF_SEED2 = 16'h7F35;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/edge_memory3_if.sv
// edge_memory3_if: decoder-side bus of the triple-lane edge memory
interface edge_memory3_if;
    logic       EN;
    logic [2:0] BitIN;
    logic [2:0] HOLD;
    logic [2:0] BitOUT;
    logic       FILLED;
    modport master (output EN, BitIN, HOLD, input BitOUT, FILLED);
    modport slave (input EN, BitIN, HOLD, output BitOUT, FILLED);
endinterface

// File: rtl/em_lane.sv
// em_lane: one edge-memory lane with circular bit store and LFSR replay address
module em_lane
    import em_pkg::*;
#(
    parameter int          DEPTH = EM_DEPTH,
    parameter int          AW    = EM_AW,
    parameter logic [15:0] SEED  = DEF_SEED0
) (
    input  logic CLK,
    input  logic INIT_N,
    input  logic EN,
    input  logic bit_in,
    input  logic hold,
    output logic bit_out,
    output logic full
);
    // bit k resets to k[0]: alternating pattern, probability 0.5
    localparam logic [DEPTH-1:0] ALT = {(DEPTH/2){2'b10}};
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wptr;
    logic [AW:0]      wcnt;
    logic [15:0]      lfsr;
    logic [AW-1:0]    raddr;
    logic             rd_bit;
    assign raddr  = lfsr[AW-1:0];
    assign rd_bit = mem[raddr];
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            mem     <= ALT;
            wptr    <= '0;
            wcnt    <= '0;
            full    <= 1'b0;
            bit_out <= 1'b0;
            lfsr    <= SEED;
        end else if (EN) begin
            lfsr    <= lfsr_next(lfsr);
            bit_out <= hold ? rd_bit : bit_in;
            if (!hold) begin
                mem[wptr] <= bit_in;
                wptr      <= wptr + 1'b1;
                wcnt      <= (wcnt == CNT_MAX) ? wcnt : wcnt + 1'b1;
                full      <= full | (wcnt == CNT_LAST);
            end
        end
    end
endmodule

// File: rtl/edge_memory3.sv
// edge_memory3: three independent edge-memory lanes feeding the hard-decision counter
module edge_memory3
    import em_pkg::*;
#(
    parameter int          DEPTH = EM_DEPTH,
    parameter int          AW    = EM_AW,
    parameter logic [15:0] SEED0 = DEF_SEED0,
    parameter logic [15:0] SEED1 = DEF_SEED1,
    parameter logic [15:0] SEED2 = DEF_SEED2
) (
    input logic           CLK,
    input logic           INIT_N,
    edge_memory3_if.slave bus
);
    localparam logic [2:0][15:0] SEEDS = {SEED2, SEED1, SEED0};
    logic [2:0] bit_out;
    logic [2:0] full;
    for (genvar g = 0; g < 3; g++) begin : g_lane
        em_lane #(.DEPTH(DEPTH), .AW(AW), .SEED(SEEDS[g])) u_lane (
            .CLK     (CLK),
            .INIT_N  (INIT_N),
            .EN      (bus.EN),
            .bit_in  (bus.BitIN[g]),
            .hold    (bus.HOLD[g]),
            .bit_out (bit_out[g]),
            .full    (full[g])
        );
    end
    assign bus.BitOUT = bit_out;
    assign bus.FILLED = &full;
    a_hold_known: assert property (@(posedge CLK) disable iff (!INIT_N) bus.EN |-> !$isunknown(bus.HOLD));
endmodule
